// File: rtl/regfile_pkg.sv
// Shared constants and types for the general register file and HI/LO pair.
package regfile_pkg;

    // Register address width (RegAddrBus = 4:0) and data width (RegBus = 31:0)
    localparam int RegAddrWidth = 5;
    localparam int RegDataWidth = 32;
    localparam int RegNum       = 32;

    typedef logic [RegAddrWidth-1:0] reg_addr_t;
    typedef logic [RegDataWidth-1:0] reg_data_t;

    localparam reg_data_t ZeroWord    = 32'h0000_0000;
    localparam reg_addr_t NOPRegAddr  = 5'b00000;
    localparam logic      RstEnable   = 1'b1;
    localparam logic      WriteEnable = 1'b1;
    localparam logic      ReadEnable  = 1'b1;

    // Number of combinational read ports on the GPR array
    localparam int ReadPorts = 2;

endpackage

// File: rtl/regfile_if.sv
// Bus bundle between the pipeline (master) and the register file (slave).
interface regfile_if;
    import regfile_pkg::*;

    logic      we;
    reg_addr_t waddr;
    reg_data_t wdata;
    logic      re1;
    reg_addr_t raddr1;
    reg_data_t rdata1;
    logic      re2;
    reg_addr_t raddr2;
    reg_data_t rdata2;
    logic      whilo;
    reg_data_t hi_i;
    reg_data_t lo_i;
    reg_data_t hi_o;
    reg_data_t lo_o;

    modport master (
        output we, waddr, wdata,
        output re1, raddr1, re2, raddr2,
        output whilo, hi_i, lo_i,
        input  rdata1, rdata2, hi_o, lo_o
    );

    modport slave (
        input  we, waddr, wdata,
        input  re1, raddr1, re2, raddr2,
        input  whilo, hi_i, lo_i,
        output rdata1, rdata2, hi_o, lo_o
    );

endinterface

// File: rtl/regfile_hilo_reg.sv
// HI/LO multiply/divide result pair: written together, read back registered.
module hilo_reg
    import regfile_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      we,
    input  reg_data_t hi_i,
    input  reg_data_t lo_i,
    output reg_data_t hi_o,
    output reg_data_t lo_o
);

    reg_data_t hi_reg;
    reg_data_t lo_reg;

    // Capture HI and LO as a pair; reset clears both immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            hi_reg <= ZeroWord;
            lo_reg <= ZeroWord;
        end else if (we == WriteEnable) begin
            hi_reg <= hi_i;
            lo_reg <= lo_i;
        end
    end

    // Outputs come straight from the flops: a write is visible the next cycle
    assign hi_o = hi_reg;
    assign lo_o = lo_reg;

endmodule

// File: rtl/regfile.sv
// 32 x 32-bit general register file with two combinational read ports,
// write-through bypass, hard-wired zero register and a HI/LO pair.
module regfile
    import regfile_pkg::*;
(
    input logic     clk,
    input logic     rst,
    regfile_if.slave bus
);

    reg_data_t regs [RegNum];
    reg_data_t hi_q;
    reg_data_t lo_q;

    // GPR write port; address 0 is never written so it stays ZeroWord after reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            for (int i = 0; i < RegNum; i++) begin
                regs[i] <= ZeroWord;
            end
        end else if (bus.we == WriteEnable && bus.waddr != NOPRegAddr) begin
            regs[bus.waddr] <= bus.wdata;
        end
    end

    // Identical read logic for each port; port 0 feeds rdata1, port 1 feeds rdata2
    for (genvar gi = 0; gi < ReadPorts; gi++) begin : g_rport
        logic      re;
        reg_addr_t raddr;
        reg_data_t rd;

        assign re    = (gi == 0) ? bus.re1    : bus.re2;
        assign raddr = (gi == 0) ? bus.raddr1 : bus.raddr2;

        // Priority: reset, disabled port, zero register, bypass, then storage
        always_comb begin
            rd = ZeroWord;
            if (rst == RstEnable) begin
                rd = ZeroWord;
            end else if (re != ReadEnable) begin
                rd = ZeroWord;
            end else if (raddr == NOPRegAddr) begin
                rd = ZeroWord;
            end else if (bus.we == WriteEnable && raddr == bus.waddr) begin
                rd = bus.wdata;
            end else begin
                rd = regs[raddr];
            end
        end
    end

    assign bus.rdata1 = g_rport[0].rd;
    assign bus.rdata2 = g_rport[1].rd;

    hilo_reg u_hilo_reg (
        .clk  (clk),
        .rst  (rst),
        .we   (bus.whilo),
        .hi_i (bus.hi_i),
        .lo_i (bus.lo_i),
        .hi_o (hi_q),
        .lo_o (lo_q)
    );

    assign bus.hi_o = hi_q;
    assign bus.lo_o = lo_q;

endmodule

// File: tb/tb_regfile.sv
// Directed testbench for regfile: one task per scenario, inline checks.
module tb_regfile;
    import regfile_pkg::*;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    regfile_if bus ();

    regfile dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.we     = 1'b0;
        bus.waddr  = 5'd0;
        bus.wdata  = 32'h0;
        bus.re1    = 1'b0;
        bus.raddr1 = 5'd0;
        bus.re2    = 1'b0;
        bus.raddr2 = 5'd0;
        bus.whilo  = 1'b0;
        bus.hi_i   = 32'h0;
        bus.lo_i   = 32'h0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.re1 = 1'b1; bus.raddr1 = 5'd5;
        bus.re2 = 1'b1; bus.raddr2 = 5'd31;
        bus.we = 1'b1; bus.waddr = 5'd5; bus.wdata = 32'hFFFF_FFFF;
        bus.whilo = 1'b1; bus.hi_i = 32'h1111_1111; bus.lo_i = 32'h2222_2222;
        #1;
        tests_run++;
        if (bus.rdata1 !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_rdata1 got %h expected %h", bus.rdata1, 32'h0);
        end
        tick();
        tests_run++;
        if (bus.rdata2 !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_rdata2 got %h expected %h", bus.rdata2, 32'h0);
        end
        tests_run++;
        if (bus.hi_o !== 32'h0 || bus.lo_o !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_hilo got %h/%h expected 0/0", bus.hi_o, bus.lo_o);
        end
        bus.we = 1'b0; bus.whilo = 1'b0;
        rst = 1'b0;
        #1;
        tests_run++;
        if (bus.rdata1 !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_r5_after got %h expected %h", bus.rdata1, 32'h0);
        end
        $display("[TB] test_reset done");
    endtask

    task automatic test_basic();
        idle_inputs();
        bus.we = 1'b1; bus.waddr = 5'd7; bus.wdata = 32'hDEAD_BEEF;
        tick();
        bus.we = 1'b0;
        bus.re1 = 1'b1; bus.raddr1 = 5'd7;
        #1;
        tests_run++;
        if (bus.rdata1 !== 32'hDEAD_BEEF) begin
            tests_failed++;
            $display("FAIL basic_read_r7 got %h expected %h", bus.rdata1, 32'hDEAD_BEEF);
        end
        bus.re1 = 1'b0;
        #1;
        tests_run++;
        if (bus.rdata1 !== 32'h0) begin
            tests_failed++;
            $display("FAIL basic_re1_off got %h expected %h", bus.rdata1, 32'h0);
        end
        $display("[TB] test_basic done");
    endtask

    task automatic test_zero_reg();
        idle_inputs();
        bus.we = 1'b1; bus.waddr = 5'd0; bus.wdata = 32'h1234_5678;
        bus.re1 = 1'b1; bus.raddr1 = 5'd0;
        bus.re2 = 1'b1; bus.raddr2 = 5'd0;
        #1;
        tests_run++;
        if (bus.rdata1 !== 32'h0 || bus.rdata2 !== 32'h0) begin
            tests_failed++;
            $display("FAIL zero_same_cycle got %h/%h expected 0/0", bus.rdata1, bus.rdata2);
        end
        tick();
        bus.we = 1'b0;
        #1;
        tests_run++;
        if (bus.rdata1 !== 32'h0 || bus.rdata2 !== 32'h0) begin
            tests_failed++;
            $display("FAIL zero_after_write got %h/%h expected 0/0", bus.rdata1, bus.rdata2);
        end
        $display("[TB] test_zero_reg done");
    endtask

    task automatic test_bypass();
        idle_inputs();
        bus.we = 1'b1; bus.waddr = 5'd3; bus.wdata = 32'hA5A5_A5A5;
        bus.re1 = 1'b1; bus.raddr1 = 5'd3;
        bus.re2 = 1'b1; bus.raddr2 = 5'd3;
        #1;
        tests_run++;
        if (bus.rdata1 !== 32'hA5A5_A5A5 || bus.rdata2 !== 32'hA5A5_A5A5) begin
            tests_failed++;
            $display("FAIL bypass_both got %h/%h expected a5a5a5a5", bus.rdata1, bus.rdata2);
        end
        tick();
        bus.we = 1'b0;
        #1;
        tests_run++;
        if (bus.rdata1 !== 32'hA5A5_A5A5 || bus.rdata2 !== 32'hA5A5_A5A5) begin
            tests_failed++;
            $display("FAIL bypass_stored got %h/%h expected a5a5a5a5", bus.rdata1, bus.rdata2);
        end
        // Disabled port must not see the bypass; enabled port must
        bus.we = 1'b1; bus.wdata = 32'h1111_1111;
        bus.re1 = 1'b0;
        #1;
        tests_run++;
        if (bus.rdata1 !== 32'h0 || bus.rdata2 !== 32'h1111_1111) begin
            tests_failed++;
            $display("FAIL bypass_re_off got %h/%h expected 0/11111111", bus.rdata1, bus.rdata2);
        end
        // Withdraw the write before the edge: storage value returns
        bus.we = 1'b0; bus.re1 = 1'b1;
        #1;
        tests_run++;
        if (bus.rdata1 !== 32'hA5A5_A5A5 || bus.rdata2 !== 32'hA5A5_A5A5) begin
            tests_failed++;
            $display("FAIL bypass_withdrawn got %h/%h expected a5a5a5a5", bus.rdata1, bus.rdata2);
        end
        $display("[TB] test_bypass done");
    endtask

    task automatic test_both_commit();
        idle_inputs();
        bus.we = 1'b1; bus.waddr = 5'd9; bus.wdata = 32'hCAFE_F00D;
        bus.whilo = 1'b1; bus.hi_i = 32'h0000_AAAA; bus.lo_i = 32'h0000_5555;
        #1;
        tests_run++;
        if (bus.hi_o !== 32'h0 || bus.lo_o !== 32'h0) begin
            tests_failed++;
            $display("FAIL hilo_no_bypass got %h/%h expected 0/0", bus.hi_o, bus.lo_o);
        end
        tick();
        bus.we = 1'b0; bus.whilo = 1'b0;
        bus.re2 = 1'b1; bus.raddr2 = 5'd9;
        #1;
        tests_run++;
        if (bus.rdata2 !== 32'hCAFE_F00D) begin
            tests_failed++;
            $display("FAIL both_commit_gpr got %h expected %h", bus.rdata2, 32'hCAFE_F00D);
        end
        tests_run++;
        if (bus.hi_o !== 32'h0000_AAAA || bus.lo_o !== 32'h0000_5555) begin
            tests_failed++;
            $display("FAIL both_commit_hilo got %h/%h expected 0000aaaa/00005555", bus.hi_o, bus.lo_o);
        end
        $display("[TB] test_both_commit done");
    endtask

    task automatic test_back_to_back();
        idle_inputs();
        for (int i = 1; i <= 4; i++) begin
            bus.we = 1'b1; bus.waddr = 5'(i + 20); bus.wdata = 32'h1000_0000 * i + 32'(i);
            tick();
        end
        bus.we = 1'b0;
        bus.re1 = 1'b1; bus.raddr1 = 5'd21;
        bus.re2 = 1'b1; bus.raddr2 = 5'd22;
        #1;
        tests_run++;
        if (bus.rdata1 !== 32'h1000_0001 || bus.rdata2 !== 32'h2000_0002) begin
            tests_failed++;
            $display("FAIL b2b_r21_r22 got %h/%h expected 10000001/20000002", bus.rdata1, bus.rdata2);
        end
        bus.raddr1 = 5'd24; bus.raddr2 = 5'd23;
        #1;
        tests_run++;
        if (bus.rdata1 !== 32'h4000_0004 || bus.rdata2 !== 32'h3000_0003) begin
            tests_failed++;
            $display("FAIL b2b_r24_r23 got %h/%h expected 40000004/30000003", bus.rdata1, bus.rdata2);
        end
        $display("[TB] test_back_to_back done");
    endtask

    task automatic test_hilo_reset();
        idle_inputs();
        bus.whilo = 1'b1; bus.hi_i = 32'h1; bus.lo_i = 32'h2;
        tick();
        bus.whilo = 1'b0;
        bus.re1 = 1'b1; bus.raddr1 = 5'd7;
        #1;
        tests_run++;
        if (bus.hi_o !== 32'h1 || bus.lo_o !== 32'h2) begin
            tests_failed++;
            $display("FAIL hilo_write got %h/%h expected 1/2", bus.hi_o, bus.lo_o);
        end
        tests_run++;
        if (bus.rdata1 !== 32'hDEAD_BEEF) begin
            tests_failed++;
            $display("FAIL hilo_r7_before got %h expected %h", bus.rdata1, 32'hDEAD_BEEF);
        end
        // Pulse reset between edges
        rst = 1'b1;
        #1;
        tests_run++;
        if (bus.hi_o !== 32'h0 || bus.lo_o !== 32'h0 || bus.rdata1 !== 32'h0) begin
            tests_failed++;
            $display("FAIL hilo_async_rst got %h/%h r7 %h expected 0/0/0", bus.hi_o, bus.lo_o, bus.rdata1);
        end
        rst = 1'b0;
        #1;
        tests_run++;
        if (bus.rdata1 !== 32'h0 || bus.hi_o !== 32'h0) begin
            tests_failed++;
            $display("FAIL hilo_r7_cleared got r7 %h hi %h expected 0/0", bus.rdata1, bus.hi_o);
        end
        $display("[TB] test_hilo_reset done");
    endtask

    task automatic test_write_during_reset();
        idle_inputs();
        bus.we = 1'b1; bus.waddr = 5'd10; bus.wdata = 32'h0000_0077;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.we = 1'b0;
        bus.re1 = 1'b1; bus.raddr1 = 5'd10;
        #1;
        tests_run++;
        if (bus.rdata1 !== 32'h0) begin
            tests_failed++;
            $display("FAIL rst_write_lost got %h expected %h", bus.rdata1, 32'h0);
        end
        bus.we = 1'b1; bus.wdata = 32'h0000_0088;
        tick();
        bus.we = 1'b0;
        #1;
        tests_run++;
        if (bus.rdata1 !== 32'h0000_0088) begin
            tests_failed++;
            $display("FAIL first_write_after_rst got %h expected %h", bus.rdata1, 32'h0000_0088);
        end
        $display("[TB] test_write_during_reset done");
    endtask

    // Global time limit so the run always ends
    initial begin
        #50000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst = 1'b0;
        idle_inputs();
        #2;
        test_reset();
        test_basic();
        test_zero_reg();
        test_bypass();
        test_both_commit();
        test_back_to_back();
        test_hilo_reset();
        test_write_during_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/regfile.md
REGFILE -- requirements
Module: regfile

Interface
REQ-001 The block SHALL take these shared constants, one per line as name, default, meaning:
  RegAddrBus, 4:0, register address width, 5 bits.
  RegBus, 31:0, data width, 32 bits.
  RegNum, 32, number of general registers.
  ZeroWord, 32'h0, zero data value.
  NOPRegAddr, 5'b00000, null register address.
REQ-002 The block SHALL have these ports, one per line as name, direction, width, meaning:
  clk  in  1  single clock; all writes on the rising edge.
  rst  in  1  asynchronous, active-high reset (RstEnable = 1).
  we  in  1  write enable, from wb_wreg.
  waddr  in  5  write register address, from wb_wd.
  wdata  in  32  write data, from wb_wdata.
  re1  in  1  read port 1 enable.
  raddr1  in  5  read port 1 address.
  rdata1  out  32  read port 1 data.
  re2  in  1  read port 2 enable.
  raddr2  in  5  read port 2 address.
  rdata2  out  32  read port 2 data.
  whilo  in  1  HI/LO write enable.
  hi_i  in  32  HI write data.
  lo_i  in  32  LO write data.
  hi_o  out  32  HI register value.
  lo_o  out  32  LO register value.

Function
REQ-003 Writes: on each posedge clk with rst low, we=1 and waddr!=0, regs[waddr] SHALL take wdata.
REQ-004 A write to address 0 SHALL be dropped; regs[0] SHALL always read ZeroWord.
REQ-005 Reads SHALL be combinational, with zero-cycle latency from raddrN/reN to rdataN.
REQ-006 rdataN SHALL be ZeroWord when rst=1, reN=0, or raddrN=0; these checks apply in that priority.
REQ-007 Write-through bypass: when reN=1, we=1 and raddrN==waddr!=0, rdataN SHALL be wdata in the same cycle.
REQ-008 Otherwise rdataN SHALL be regs[raddrN].
REQ-009 Both read ports SHALL be independent; same-address reads on both ports SHALL return identical data, including when bypassed.
REQ-010 HI/LO: on posedge clk with rst low and whilo=1, HI/LO SHALL take hi_i/lo_i together. hi_o/lo_o SHALL be registered, visible the cycle after the write, with no bypass.
REQ-011 A GPR write and a HI/LO write in the same cycle SHALL both commit.

Reset
REQ-012 rst=1 SHALL immediately (asynchronously) clear all 32 GPRs, HI and LO to ZeroWord.
REQ-013 While rst=1: rdata1, rdata2, hi_o and lo_o SHALL be ZeroWord, and all writes SHALL be ignored.
REQ-014 If rst asserts in the same cycle as a write, the write SHALL be lost. The first write SHALL take effect on the first posedge after rst deasserts.

Structure
REQ-015 RegAddrBus, RegBus, RegNum, ZeroWord, NOPRegAddr, RstEnable, WriteEnable and ReadEnable SHALL live in the shared defines.v.
REQ-016 HI/LO storage SHALL be a sub-module, hilo_reg, instantiated once inside regfile.
REQ-017 GPR storage SHALL be an array of RegNum x RegBus bits; no other sub-modules.

Verification
REQ-018 Reset: hold rst=1 with re1=re2=1 and raddr1=5, raddr2=31 -> rdata1=rdata2=0. Release rst, read reg 5 -> 0.
REQ-019 Basic write/read: write 32'hDEADBEEF to r7, next cycle re1=1, raddr1=7 -> rdata1=32'hDEADBEEF. With re1=0 -> rdata1=0.
REQ-020 Zero register: write 32'h12345678 to r0, then read r0 on both ports, including in the same cycle as the write -> rdata=0.
REQ-021 Bypass: in one cycle drive we=1, waddr=3, wdata=32'hA5A5A5A5 and raddr1=raddr2=3 -> both rdata=32'hA5A5A5A5 combinationally. Following cycle, with we=0 -> same value from storage.
REQ-022 HI/LO with mid-run reset: whilo=1, hi_i=1, lo_i=2 -> next cycle hi_o=1, lo_o=2. Pulse rst between edges -> hi_o=lo_o=0 and r7 reads 0 immediately.
